// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module uart_tx_engine #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               en,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic [7:0]         wdata,
    input  logic               wvalid,
    output logic               wready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             r_state;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wptr;
    logic [FIFO_AW:0]   r_rptr;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit;
    logic               r_tx;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_tick;
    logic [DIV_W-1:0]   w_div_eff;
    logic [7:0]         w_head;

    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = wvalid && !w_full;
    assign w_tick  = (r_cnt == '0);
    assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];

    // Divisors below 2 would collapse the down-counter, so clamp them.
    assign w_div_eff = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;

    // A new frame may start from IDLE or straight out of a finished stop bit.
    assign w_pop = en && !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

    assign wready = !w_full;
    assign level  = r_wptr - r_rptr;
    assign tx     = r_tx;
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '{default: '0};
        end else begin
            if (w_push) begin
                r_mem[r_wptr[FIFO_AW-1:0]] <= wdata;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_div   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_div   <= w_div_eff;
            r_cnt   <= w_div_eff - DIV_W'(1);
            r_shift <= w_head;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^w_head;
`endif
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_cnt <= r_div - DIV_W'(1);
                unique case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame timing, FIFO limits, reset.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_engine;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        en;
    logic [15:0] baud_div;
    logic [7:0]  wdata;
    logic        wvalid;
    logic        wready;
    logic        tx;
    logic        busy;
    logic [2:0]  level;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx_engine #(.DIV_W(16), .FIFO_AW(2)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .en       (en),
        .baud_div (baud_div),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .tx       (tx),
        .busy     (busy),
        .level    (level)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wdata  = b;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
    endtask

    // Entered 1 time unit after the edge that drove the start bit.
    task automatic frame(input logic [7:0] b, input int div);
        logic [10:0] seq;
        logic [7:0]  rx;
        int          nb;
        int          bad;
        rx = '0;
`ifdef UART_TX_PARITY_EN
        nb  = 11;
        seq = {1'b1, ^b, b, 1'b0};
`else
        nb  = 10;
        seq = {1'b1, 1'b1, b, 1'b0};
`endif
        for (int k = 0; k < nb; k++) begin
            bad = 0;
            for (int c = 0; c < div; c++) begin
                if (tx !== seq[k]) bad++;
                if (k >= 1 && k <= 8 && c == div / 2) rx[k-1] = tx;
                tick();
            end
            chk($sformatf("frame_%02h_bit%0d_bad_cycles", b, k), bad, 0);
        end
        chk("rx_byte", rx, b);
        $display("uart monitor: rx 0x%02h '%c'", rx, rx);
    endtask

    initial begin
        int lows;
        HRESETn  = 1'b0;
        en       = 1'b1;
        baud_div = 16'd16;
        wdata    = 8'h00;
        wvalid   = 1'b0;
        tick();
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_wready", wready, 1);

        // Single byte 'A', start 1 cycle after the write
        HRESETn = 1'b1;
        push(8'h41);
        chk("a_level_after_write", level, 1);
        chk("a_tx_idle_after_write", tx, 1);
        tick();
        chk("a_start_tx", tx, 0);
        chk("a_start_busy", busy, 1);
        chk("a_level_popped", level, 0);
        frame(8'h41, 16);
        chk("a_idle_busy", busy, 0);
        chk("a_idle_tx", tx, 1);

        // Fill FIFO while disabled, 5th write dropped
        en = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("fill_wready_3", wready, 1);
        push(8'h44);
        chk("full_wready", wready, 0);
        chk("full_level", level, 4);
        push(8'h5A);
        chk("drop_level", level, 4);
        en = 1'b1;
        tick();
        chk("b2b_start0", tx, 0);
        chk("b2b_level3", level, 3);
        chk("b2b_wready_after_pop", wready, 1);
        frame(8'h11, 16);
        chk("b2b_start1", tx, 0);
        chk("b2b_level2", level, 2);
        frame(8'h22, 16);
        chk("b2b_start2", busy, 1);
        chk("b2b_level1", level, 1);
        frame(8'h33, 16);
        chk("b2b_start3", tx, 0);
        chk("b2b_level0", level, 0);
        frame(8'h44, 16);
        chk("b2b_done_busy", busy, 0);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        chk("b2b_no_fifth_frame", lows, 0);

        // Enable gating
        en = 1'b0;
        push(8'h55);
        for (int i = 0; i < 100; i++) tick();
        chk("en0_tx", tx, 1);
        chk("en0_busy", busy, 0);
        chk("en0_level", level, 1);
        en = 1'b1;
        tick();
        chk("en1_start_tx", tx, 0);
        chk("en1_start_busy", busy, 1);
        frame(8'h55, 16);

        // Divisor clamping and mid-frame divisor change
        baud_div = 16'd0;
        push(8'hA5);
        tick();
        chk("div0_start", tx, 0);
        frame(8'hA5, 2);
        baud_div = 16'd1;
        push(8'h3C);
        tick();
        frame(8'h3C, 2);
        baud_div = 16'd16;
        en = 1'b0;
        push(8'h81);
        push(8'h7E);
        en = 1'b1;
        tick();
        chk("div_chg_start", tx, 0);
        baud_div = 16'd8;
        frame(8'h81, 16);
        chk("div_chg_second_start", tx, 0);
        frame(8'h7E, 8);

        // Reset during data bit 3
        baud_div = 16'd16;
        en = 1'b0;
        push(8'hF0);
        push(8'h0F);
        en = 1'b1;
        tick();
        for (int i = 0; i < 69; i++) tick();
        chk("pre_rst_bit3_low", tx, 0);
        chk("pre_rst_level", level, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_level", level, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_wready", wready, 1);
        tick();
        HRESETn = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        chk("post_rst_no_frame", lows, 0);
        chk("post_rst_level", level, 0);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        tick();
        frame(8'h07, 16);
        chk("par07_idle", busy, 0);
        push(8'h03);
        tick();
        frame(8'h03, 16);
        chk("par03_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DIV_W, default 16, width of the baud divisor.
REQ-002 Parameter FIFO_AW, default 2, log2 of the transmit FIFO depth (depth = 2**FIFO_AW).
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  transmit enable; when 0, no new frame starts.
REQ-006 baud_div  input  DIV_W  bit period in HCLK cycles; values 0 and 1 are treated as 2.
REQ-007 wdata  input  8  byte to enqueue.
REQ-008 wvalid  input  1  wdata is valid this cycle.
REQ-009 wready  output  1  FIFO can accept a byte; equals FIFO not full, registered-state only with no combinational path from wvalid.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 busy  output  1  high while a frame is on the line (state not IDLE).
REQ-012 level  output  FIFO_AW+1  number of bytes held in the FIFO.

Function
REQ-013 A byte is enqueued on a rising edge with wvalid=1 and wready=1; a write with wready=0 is dropped, and FIFO contents and level are unchanged.
REQ-014 The FSM states are IDLE, START, DATA, PARITY (only with the macro in REQ-026), and STOP.
REQ-015 In IDLE with en=1 and level>0, the next edge pops the FIFO head into the shift register, latches the effective baud_div, enters START and drives tx=0.
REQ-016 Each state holds tx constant for exactly the latched divisor count of cycles, measured by a down-counter reloaded on every bit boundary.
REQ-017 DATA sends 8 bits LSB first, then goes to PARITY if present, otherwise to STOP.
REQ-018 STOP drives tx=1 for one bit period; at its end, if en=1 and level>0, the FSM goes directly to START (back-to-back, no idle gap), otherwise to IDLE.
REQ-019 A push and a pop on the same edge leave level unchanged; a pop while full allows a push on the following cycle only.
REQ-020 The read and write pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1); full = MSBs differ with the rest equal; empty = pointers equal.
REQ-021 Deasserting en mid-frame does not abort the frame: the frame completes, then the FSM idles.
REQ-022 Changing baud_div mid-frame takes effect only at the next frame start.

Reset
REQ-023 While HRESETn=0, the block holds tx=1, busy=0, level=0 and wready=1, with the FSM in IDLE and pointers, counter and shift register cleared.
REQ-024 Reset asserted mid-frame forces tx=1 immediately (asynchronously) and discards the FIFO contents.
REQ-025 After HRESETn deasserts, the first frame starts no earlier than the second rising edge.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) is sent for one bit period between DATA and STOP, giving an 11-bit frame; when undefined, the PARITY state and its logic are absent, giving a 10-bit frame.

Verification
REQ-027 baud_div=16, en=1, write 0x41 -> tx low 16 cycles starting 1 cycle after the write, then bits 1,0,0,0,0,0,1,0 at 16 cycles each, then stop high; the bench UART monitor at 160 ns bit time prints 'A'.
REQ-028 Write 4 bytes back-to-back, then a 5th while full -> wready=0 after the 4th write, the 5th byte is dropped, exactly 4 contiguous frames with no idle gap, and level counts 4,3,2,1,0.
REQ-029 Set en=0, write 0x55, wait 100 cycles -> tx=1, busy=0, level=1; then set en=1 -> frame starts on the next edge.
REQ-030 baud_div=0 -> every bit lasts 2 cycles; change baud_div from 16 to 8 mid-frame -> the current frame stays at 16 cycles per bit and the next frame uses 8.
REQ-031 Assert HRESETn=0 during data bit 3 -> tx=1 within the same cycle, level=0, and no further frame occurs after release.
REQ-032 With UART_TX_PARITY_EN defined, write 0x07 -> parity bit=1 and a frame length of 11 bit periods; write 0x03 -> parity bit=0.
